// File: rtl/dm_store_buffer.sv
// +-----------------------------------------------------------------------------
// | Module      : dm_store_buffer
// | Description : Posted-write FIFO between the store path and data memory, with
// |               alignment rejection and word-granular load-hazard detection.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [31:0]              st_data,
  input  logic                     st_byte,
  input  logic                     st_hbyte,
  input  logic [31:0]              st_pc,
  output logic                     st_ready,
  output logic                     st_err,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_stall,
  input  logic                     drain_en,
  output logic                     dm_WrEn,
  output logic [AW-1:0]            dm_MemAddr,
  output logic [31:0]              dm_DataIn,
  output logic                     dm_Byte,
  output logic                     dm_HByte,
  output logic [31:0]              dm_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int c_PW = $clog2(DEPTH);
  localparam logic [c_PW:0] c_FULL = (c_PW + 1)'(DEPTH);

  logic [AW-1:0]      r_addrMem  [DEPTH];
  logic [31:0]        r_dataMem  [DEPTH];
  logic [31:0]        r_pcMem    [DEPTH];
  logic               r_byteMem  [DEPTH];
  logic               r_hbyteMem [DEPTH];

  logic [c_PW-1:0]    r_wrPtr;
  logic [c_PW-1:0]    r_rdPtr;
  logic [c_PW:0]      r_count;
  logic [DEPTH-1:0]   r_valid;
  logic               r_err;

  logic               w_empty;
  logic               w_aligned;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_hit;
  logic [DEPTH-1:0]   w_validNext;

  assign w_empty   = (r_count == '0);
  assign st_ready  = (r_count < c_FULL);
  assign w_aligned = st_byte ? 1'b1 :
                     st_hbyte ? ~st_addr[0] : (st_addr[1:0] == 2'b00);
  assign w_accept  = st_valid && st_ready;
  assign w_push    = w_accept && w_aligned;
  assign w_pop     = !w_empty && drain_en;

  // Per-slot valid bits let the hazard compare scan slots without pointer math.
  always_comb begin
    w_validNext = r_valid;
    if (w_pop)  w_validNext[r_rdPtr] = 1'b0;
    if (w_push) w_validNext[r_wrPtr] = 1'b1;
  end

  // A draining entry still blocks; so does the store being pushed this cycle.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addrMem[i][AW-1:2] == ld_addr[AW-1:2])) w_hit = 1'b1;
    end
    if (w_push && (st_addr[AW-1:2] == ld_addr[AW-1:2])) w_hit = 1'b1;
  end

  assign ld_stall = ld_valid && !Reset && w_hit;

  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_addrMem[r_wrPtr]  <= st_addr;
      r_dataMem[r_wrPtr]  <= st_data;
      r_pcMem[r_wrPtr]    <= st_pc;
      r_byteMem[r_wrPtr]  <= st_byte;
      r_hbyteMem[r_wrPtr] <= st_hbyte & ~st_byte;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err   <= w_accept && !w_aligned;
      r_valid <= w_validNext;
      if (w_push) r_wrPtr <= r_wrPtr + c_PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + c_PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PW + 1)'(1);
        2'b01:   r_count <= r_count - (c_PW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign st_err     = r_err;
  assign count      = r_count;
  assign empty      = w_empty;
  assign dm_WrEn    = w_pop;
  assign dm_MemAddr = w_empty ? '0    : r_addrMem[r_rdPtr];
  assign dm_DataIn  = w_empty ? '0    : r_dataMem[r_rdPtr];
  assign dm_pc      = w_empty ? '0    : r_pcMem[r_rdPtr];
  assign dm_Byte    = w_empty ? 1'b0  : r_byteMem[r_rdPtr];
  assign dm_HByte   = w_empty ? 1'b0  : r_hbyteMem[r_rdPtr];

endmodule

`default_nettype wire

// File: tb/tb_dm_store_buffer.sv
// +-----------------------------------------------------------------------------
// | Module      : tb_dm_store_buffer
// | Description : Self-checking bench for dm_store_buffer against a queue model.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_dm_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        st_valid, st_byte, st_hbyte, ld_valid, drain_en;
  logic [31:0] st_addr, st_data, st_pc, ld_addr;
  logic        st_ready, st_err, ld_stall, dm_WrEn, dm_Byte, dm_HByte, empty;
  logic [31:0] dm_MemAddr, dm_DataIn, dm_pc;
  logic [2:0]  count;

  dm_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk(Clk), .Reset(Reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_byte(st_byte), .st_hbyte(st_hbyte), .st_pc(st_pc),
    .st_ready(st_ready), .st_err(st_err),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .drain_en(drain_en), .dm_WrEn(dm_WrEn), .dm_MemAddr(dm_MemAddr),
    .dm_DataIn(dm_DataIn), .dm_Byte(dm_Byte), .dm_HByte(dm_HByte),
    .dm_pc(dm_pc), .count(count), .empty(empty)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
    logic        b;
    logic        h;
  } entry_t;

  entry_t q[$];
  logic   errExp;
  int     nErrors = 0;
  int     nChecks = 0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit misaligned(input logic [31:0] a, input logic b, input logic h);
    if (b) return 1'b0;
    if (h) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  // Checks every output at the falling edge, then advances the model one cycle.
  task automatic runCycle();
    entry_t e;
    logic   expStall;
    bit     acc;
    @(negedge Clk);
    e = '{default: '0};
    if (q.size() > 0) e = q[0];
    acc = st_valid && (q.size() < DEPTH);
    checkVal("st_ready", st_ready, q.size() < DEPTH);
    checkVal("count", count, q.size());
    checkVal("empty", empty, q.size() == 0);
    checkVal("st_err", st_err, errExp);
    checkVal("dm_WrEn", dm_WrEn, (q.size() > 0) && drain_en);
    checkVal("dm_MemAddr", dm_MemAddr, e.addr);
    checkVal("dm_DataIn", dm_DataIn, e.data);
    checkVal("dm_pc", dm_pc, e.pc);
    checkVal("dm_Byte", dm_Byte, e.b);
    checkVal("dm_HByte", dm_HByte, e.h);
    expStall = 1'b0;
    if (ld_valid && !Reset) begin
      foreach (q[i]) if (q[i].addr[31:2] == ld_addr[31:2]) expStall = 1'b1;
      if (acc && !misaligned(st_addr, st_byte, st_hbyte) && st_addr[31:2] == ld_addr[31:2])
        expStall = 1'b1;
    end
    checkVal("ld_stall", ld_stall, expStall);
    if (Reset) begin
      q.delete();
      errExp = 1'b0;
    end else begin
      if (q.size() > 0 && drain_en) void'(q.pop_front());
      if (acc && !misaligned(st_addr, st_byte, st_hbyte))
        q.push_back('{addr: st_addr, data: st_data, pc: st_pc, b: st_byte, h: st_hbyte && !st_byte});
      errExp = acc && misaligned(st_addr, st_byte, st_hbyte);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic setStore(input logic v, input logic [31:0] a, input logic [31:0] d,
                          input logic b, input logic h);
    st_valid = v; st_addr = a; st_data = d; st_byte = b; st_hbyte = h;
    st_pc = 32'h1000 + (d << 2);
  endtask

  initial begin
    Reset = 1'b1; errExp = 1'b0;
    setStore(0, 0, 0, 0, 0);
    ld_valid = 0; ld_addr = 0; drain_en = 0;
    #1;
    repeat (2) runCycle();
    Reset = 1'b0;

    // Single word store, drained immediately.
    drain_en = 1;
    setStore(1, 32'h10, 32'hDEADBEEF, 0, 0);
    runCycle();
    setStore(0, 0, 0, 0, 0);
    #1;
    checkVal("single_wren", dm_WrEn, 1'b1);
    checkVal("single_addr", dm_MemAddr, 32'h10);
    checkVal("single_data", dm_DataIn, 32'hDEADBEEF);
    checkVal("single_count", count, 3'd1);
    runCycle();
    checkVal("single_empty", empty, 1'b1);

    // Fill with byte stores, fifth is refused, then drain in order.
    drain_en = 0;
    for (int i = 0; i < 5; i++) begin
      setStore(1, 32'h20 + i, 32'hA0 + i, 1, 0);
      runCycle();
    end
    setStore(0, 0, 0, 0, 0);
    checkVal("full_count", count, 3'd4);
    checkVal("full_ready", st_ready, 1'b0);
    drain_en = 1;
    for (int i = 0; i < 4; i++) begin
      checkVal("drain_order", dm_MemAddr, 32'h20 + i);
      runCycle();
    end
    checkVal("drain_empty", empty, 1'b1);

    // Misaligned word rejected, aligned halfword at the same address accepted.
    drain_en = 0;
    setStore(1, 32'h6, 32'h1234, 0, 0);
    runCycle();
    setStore(0, 0, 0, 0, 0);
    checkVal("mis_err", st_err, 1'b1);
    checkVal("mis_count", count, 3'd0);
    setStore(1, 32'h6, 32'h5678, 0, 1);
    runCycle();
    setStore(0, 0, 0, 0, 0);
    checkVal("hw_err", st_err, 1'b0);
    checkVal("hw_flag", dm_HByte, 1'b1);
    drain_en = 1;
    runCycle();

    // Load hazard on the same word, none on the next word.
    drain_en = 0;
    setStore(1, 32'h40, 32'h77, 0, 0);
    ld_valid = 1; ld_addr = 32'h43;
    runCycle();
    setStore(0, 0, 0, 0, 0);
    #1;
    checkVal("haz_hit", ld_stall, 1'b1);
    ld_addr = 32'h44;
    #1;
    checkVal("haz_miss", ld_stall, 1'b0);
    ld_addr = 32'h43;
    runCycle();
    drain_en = 1;
    runCycle();
    checkVal("haz_clear", ld_stall, 1'b0);
    ld_valid = 0;

    // Steady push/pop at count=2 across several pointer wraps.
    drain_en = 0;
    for (int i = 0; i < 2; i++) begin
      setStore(1, 32'h100 + 4 * i, 32'hC0 + i, 0, 0);
      runCycle();
    end
    drain_en = 1;
    for (int i = 2; i < 12; i++) begin
      setStore(1, 32'h100 + 4 * i, 32'hC0 + i, 0, 0);
      runCycle();
      checkVal("pp_count", count, 3'd2);
    end
    setStore(0, 0, 0, 0, 0);
    repeat (3) runCycle();

    // Randomized traffic over a small address window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      setStore($urandom_range(0, 1), $urandom_range(0, 31), $urandom,
               $urandom_range(0, 3) == 0, $urandom_range(0, 1));
      ld_valid = $urandom_range(0, 1);
      ld_addr  = $urandom_range(0, 31);
      drain_en = $urandom_range(0, 4) < 3;
      runCycle();
    end

    // Asynchronous reset in the middle of a cycle with three pending entries.
    setStore(0, 0, 0, 0, 0);
    ld_valid = 0;
    drain_en = 1;
    while (q.size() > 0) runCycle();
    drain_en = 0;
    for (int i = 0; i < 3; i++) begin
      setStore(1, 32'h200 + 4 * i, 32'hE0 + i, 0, 0);
      runCycle();
    end
    setStore(0, 0, 0, 0, 0);
    checkVal("pre_rst_count", count, 3'd3);
    drain_en = 1;
    #2 Reset = 1'b1;
    #1;
    checkVal("rst_count", count, 3'd0);
    checkVal("rst_wren", dm_WrEn, 1'b0);
    checkVal("rst_ready", st_ready, 1'b1);
    q.delete();
    errExp = 1'b0;
    repeat (2) runCycle();
    Reset = 1'b0;
    repeat (3) runCycle();

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

`default_nettype wire
